uart_rx_param: RTL and testbench

//  Parametrised UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_param_if.sv | 19 +
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_rx_param.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver slice.
//   parity_e      - parity mode encoding (matches the PARITY parameter value)
//   rx_state_e    - receiver FSM states
//   baud_cnt_max  - system clocks per bit period
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  function automatic int baud_cnt_max(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: received-word valid/ready channel.
//   po_data  - received data word (DATA_BITS wide)
//   po_perr  - parity error flag for po_data
//   po_ferr  - framing error flag for po_data
//   po_valid - word/flags valid
//   po_ready - consumer accepts the word when po_valid && po_ready
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] po_data;
  logic                 po_perr;
  logic                 po_ferr;
  logic                 po_valid;
  logic                 po_ready;

  modport master (output po_data, po_perr, po_ferr, po_valid, input po_ready);
  modport slave  (input po_data, po_perr, po_ferr, po_valid, output po_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO.
//   sys_clk/sys_rst_n - clock, async active-low reset
//   push_i/din_i      - write strobe and data (ignored when full without a pop)
//   pop_i             - removes the head entry (ignored when empty)
//   dout_o            - head entry, forced to 0 while empty
//   empty_o/full_o    - status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5..9 data bits LSB first,
// none/odd/even parity, 1 or 2 stop bits) with valid/ready word output.
//   sys_clk, sys_rst_n - clock, async active-low reset
//   rx                 - serial input, idle high, asynchronous
//   po                 - uart_rx_param_if.master: po_data/po_perr/po_ferr/po_valid, po_ready
//   overrun            - 1-cycle pulse when a completed frame is dropped for lack of room
//   busy               - FSM not in IDLE
// Build option: define UART_RX_FIFO_EN to buffer FIFO_DEPTH frames (FWFT head on po);
// otherwise a single output register holds one word.
module uart_rx_param #(
  parameter int CLK_FRE    = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             rx,
  uart_rx_param_if.master  po,
  output logic             overrun,
  output logic             busy
);
  import uart_pkg::*;

  localparam int      CNT_MAX  = baud_cnt_max(CLK_FRE, BAUD_RATE);
  localparam int      CNT_MID  = CNT_MAX / 2;
  localparam int      CNT_W    = $clog2(CNT_MAX);
  localparam int      BIT_W    = $clog2(DATA_BITS);
  localparam int      WORD_W   = DATA_BITS + 2;
  localparam parity_e PAR_MODE = parity_e'(PARITY);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_rx_param: unsupported parameter combination");
  end

  // rx synchroniser; s3 only serves the falling-edge detect. Reset to 1 so
  // leaving reset never looks like a start edge.
  logic rx_s1_q, rx_s2_q, rx_s3_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  logic rx_bit, rx_fall;
  assign rx_bit  = rx_s2_q;
  assign rx_fall = rx_s3_q & ~rx_s2_q;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 commit, cnt_end;
  logic [WORD_W-1:0]    word;

  assign cnt_end = (cnt_q == CNT_W'(CNT_MAX - 1));
  assign word    = {ferr_d, perr_q, shift_q};
  assign busy    = (state_q != IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Every state exit clears the counter: START leaves at mid-bit, so all
  // later samples (CNT_MAX-1 after each entry/wrap) land at mid-bit too.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_fall) begin
          state_d = START;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CNT_W'(CNT_MID - 1)) begin
          cnt_d   = '0;
          state_d = rx_bit ? IDLE : DATA;  // high at mid-start: glitch
        end
      end
      DATA: begin
        if (cnt_end) begin
          shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PAR_MODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (cnt_end) begin
          perr_d  = (^shift_q ^ rx_bit) != (PAR_MODE == PAR_ODD);
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_end) begin
          ferr_d = ferr_q | ~rx_bit;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // Back to IDLE mid-stop-bit so the next start edge is not missed.
            commit  = 1'b1;
            stop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic ovr_q, room;
  assign overrun = ovr_q;

`ifdef UART_RX_FIFO_EN
  logic [WORD_W-1:0] head;
  logic              empty, full, pop;

  assign pop  = !empty && po.po_ready;
  assign room = !full || pop;

  uart_rx_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .push_i   (commit && room),
    .din_i    (word),
    .pop_i    (pop),
    .dout_o   (head),
    .empty_o  (empty),
    .full_o   (full)
  );

  assign po.po_data  = head[DATA_BITS-1:0];
  assign po.po_perr  = head[DATA_BITS];
  assign po.po_ferr  = head[DATA_BITS+1];
  assign po.po_valid = !empty;
`else
  logic [WORD_W-1:0] out_q;
  logic              vld_q;

  assign room = !vld_q || po.po_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else if (commit && room) begin
      out_q <= word;
      vld_q <= 1'b1;
    end else if (vld_q && po.po_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign po.po_data  = out_q[DATA_BITS-1:0];
  assign po.po_perr  = out_q[DATA_BITS];
  assign po.po_ferr  = out_q[DATA_BITS+1];
  assign po.po_valid = vld_q;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ovr_q <= 1'b0;
    else            ovr_q <= commit && !room;
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param. Three instances cover
// 8N1, 8E1 and 7O2; expected words are queued when a frame is driven and
// checked when the consumer accepts a word.
module tb_uart_rx_param;
  localparam int BIT     = 434;
  localparam int CNT_MID = 217;
`ifdef UART_RX_FIFO_EN
  localparam int EXP_OVR = 0;
`else
  localparam int EXP_OVR = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxv, ovr, busy;
  int         n_cmp = 0, n_err = 0;
  int         vcnt [3] = '{0, 0, 0};
  int         ocnt [3] = '{0, 0, 0};
  logic [12:0] sbq [$];  // {id[1:0], ferr, perr, data[8:0]}

  always #10 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_if #(.DATA_BITS(7)) if2 ();

  uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .rx(rxv[0]), .po(if0), .overrun(ovr[0]), .busy(busy[0]));
  uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .rx(rxv[1]), .po(if1), .overrun(ovr[1]), .busy(busy[1]));
  uart_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .rx(rxv[2]), .po(if2), .overrun(ovr[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [1:0] id, input logic f, input logic p, input logic [8:0] d);
    sbq.push_back({id, f, p, d});
  endtask

  // An empty queue yields id 3, which no instance produces.
  task automatic sb_pop(input logic [1:0] id, input logic f, input logic p, input logic [8:0] d);
    logic [12:0] exp;
    exp = (sbq.size() > 0) ? sbq.pop_front() : '1;
    chk("sb_word", 32'({id, f, p, d}), 32'(exp));
  endtask

  always @(negedge clk) begin
    if (if0.po_valid) vcnt[0]++;
    if (if1.po_valid) vcnt[1]++;
    if (if2.po_valid) vcnt[2]++;
    for (int k = 0; k < 3; k++) if (ovr[k]) ocnt[k]++;
    if (if0.po_valid && if0.po_ready) sb_pop(2'd0, if0.po_ferr, if0.po_perr, 9'(if0.po_data));
    if (if1.po_valid && if1.po_ready) sb_pop(2'd1, if1.po_ferr, if1.po_perr, 9'(if1.po_data));
    if (if2.po_valid && if2.po_ready) sb_pop(2'd2, if2.po_ferr, if2.po_perr, 9'(if2.po_data));
  end

  task automatic drive(input int k, input logic v);
    rxv[k] = v;
    repeat (BIT) @(negedge clk);
  endtask

  // pbit < 0: no parity bit. stops[i] is the level of stop bit i.
  task automatic send(input int k, input logic [8:0] d, input int nb, input int pbit,
                      input logic [1:0] stops, input int nstop);
    drive(k, 1'b0);
    for (int i = 0; i < nb; i++) drive(k, d[i]);
    if (pbit >= 0) drive(k, pbit[0]);
    for (int i = 0; i < nstop; i++) drive(k, stops[i]);
    rxv[k] = 1'b1;
  endtask

  initial begin
    int v, o;
    logic [7:0] ab;
    rst_n = 1'b0;
    rxv   = '1;
    if0.po_ready = 1'b1;
    if1.po_ready = 1'b1;
    if2.po_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_valid", 32'({if0.po_valid, if1.po_valid, if2.po_valid}), 0);
    chk("rst_data0", 32'(if0.po_data), 0);
    chk("rst_flags", 32'({if0.po_perr, if0.po_ferr, if2.po_perr, if2.po_ferr}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(ovr), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 0x55, consumer always ready: valid exactly one cycle.
    v = vcnt[0];
    sb_push(2'd0, 1'b0, 1'b0, 9'h55);
    send(0, 9'h55, 8, -1, 2'b01, 1);
    repeat (20) @(negedge clk);
    chk("t1_vld_cycles", 32'(vcnt[0] - v), 1);
    chk("t1_busy", 32'(busy[0]), 0);

    // 8E1 0xA3 (four ones): parity bit 1 is wrong, 0 is right.
    sb_push(2'd1, 1'b0, 1'b1, 9'h0A3);
    send(1, 9'h0A3, 8, 1, 2'b01, 1);
    sb_push(2'd1, 1'b0, 1'b0, 9'h0A3);
    send(1, 9'h0A3, 8, 0, 2'b01, 1);
    repeat (20) @(negedge clk);

    // 7O2 0x41 (two ones, odd parity bit 1), second stop bit low.
    sb_push(2'd2, 1'b1, 1'b0, 9'h041);
    send(2, 9'h041, 7, 1, 2'b01, 2);
    repeat (20) @(negedge clk);
    chk("t3_busy", 32'(busy[2]), 0);

    // 100-cycle low glitch: no word, FSM back in IDLE by CNT_MID+3.
    v = vcnt[0];
    rxv[0] = 1'b0;
    repeat (50) @(negedge clk);
    chk("t4_busy_mid", 32'(busy[0]), 1);
    repeat (50) @(negedge clk);
    rxv[0] = 1'b1;
    repeat (CNT_MID + 3 - 100) @(negedge clk);
    chk("t4_busy_end", 32'(busy[0]), 0);
    chk("t4_no_vld", 32'(vcnt[0] - v), 0);

    // Three back-to-back frames while the consumer stalls.
    if0.po_ready = 1'b0;
    o = ocnt[0];
    sb_push(2'd0, 1'b0, 1'b0, 9'h11);
`ifdef UART_RX_FIFO_EN
    sb_push(2'd0, 1'b0, 1'b0, 9'h22);
    sb_push(2'd0, 1'b0, 1'b0, 9'h33);
`endif
    send(0, 9'h11, 8, -1, 2'b01, 1);
    send(0, 9'h22, 8, -1, 2'b01, 1);
    send(0, 9'h33, 8, -1, 2'b01, 1);
    repeat (20) @(negedge clk);
    chk("t5_hold_data", 32'(if0.po_data), 32'h11);
    chk("t5_hold_vld", 32'(if0.po_valid), 1);
    chk("t5_overrun", 32'(ocnt[0] - o), 32'(EXP_OVR));
    if0.po_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_drained", 32'(if0.po_valid), 0);

    // Stored word plus a frame cut by reset in data bit 4: nothing survives.
    if0.po_ready = 1'b0;
    send(0, 9'h5A, 8, -1, 2'b01, 1);
    repeat (10) @(negedge clk);
    chk("t6_pre_vld", 32'(if0.po_valid), 1);
    ab = 8'hA5;
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, ab[i]);
    rxv[0] = ab[4];
    repeat (BIT / 2) @(negedge clk);
    chk("t6_pre_busy", 32'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(if0.po_valid), 0);
    chk("t6_rst_data", 32'(if0.po_data), 0);
    chk("t6_rst_busy", 32'(busy[0]), 0);
    if0.po_ready = 1'b1;
    repeat (5) @(negedge clk);
    rxv[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    sb_push(2'd0, 1'b0, 1'b0, 9'h9C);
    send(0, 9'h9C, 8, -1, 2'b01, 1);
    repeat (20) @(negedge clk);

    chk("sb_left", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
